// File: rtl/pipelined_cpu_pkg.sv
// Shared definitions for the five-stage MIPS-subset pipeline.
// Holds opcode/funct constants, the forwarding-select and ALU-op encodings,
// the per-instruction control bundle and the forwarding-select helper.
package pipelined_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_MUL = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Picks the youngest in-flight producer of a non-zero source register.
  function automatic fwd_sel_e fwd_select(input logic [4:0] src,
                                          input logic       exm_we,
                                          input logic [4:0] exm_dst,
                                          input logic       mwb_we,
                                          input logic [4:0] mwb_dst);
    fwd_select = FWD_REG;
    if (src != '0) begin
      if (exm_we && exm_dst == src) fwd_select = FWD_MEM;
      else if (mwb_we && mwb_dst == src) fwd_select = FWD_WB;
    end
  endfunction

endpackage

// File: rtl/pipelined_cpu_alu.sv
// Combinational ALU for the EX stage.
// Ports: a, b - operands; op - operation select; y - result (mul keeps the
// low 32 bits of the product).
module pipelined_cpu_alu
  import pipelined_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_MUL: y = a * b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/pipelined_cpu.sv
// Five-stage in-order MIPS-subset CPU (IF, ID, EX, MEM, WB) with internal
// instruction memory (256 words), byte-wide data memory (32 bytes) and a
// 32x32 register file. Branches/jumps resolve in ID with a one-slot flush,
// load-use costs one bubble, EX operands forward from EX/MEM and MEM/WB.
// Ports: clk_i - clock; rst_i - asynchronous active-low reset;
//        start_i - run enable, the PC only advances while high.
module pipelined_cpu
  import pipelined_cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);

  logic [31:0] pc_plus4, fetch_instr, pc_target;
  logic        redirect, stall, is_beq, is_j, wb_write;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm, id_rs_val, id_rt_val;
  ctrl_t       id_ctrl;
  fwd_sel_e    fwd_a, fwd_b;
  logic [31:0] ex_a, ex_b_fwd, ex_b, ex_result, load_data, wb_data;
  logic [4:0]  ex_dst, mem_addr;

  // ---------------- IF ----------------
  if (1) begin : PC
    logic [31:0] pc_o;
    // Stall beats a redirect; a redirect still lands while draining so the
    // branch's effect is not lost.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)        pc_o <= '0;
      else if (stall)    pc_o <= pc_o;
      else if (redirect) pc_o <= pc_target;
      else if (start_i)  pc_o <= pc_plus4;
    end
  end

  if (1) begin : Instruction_Memory
    logic [31:0] memory [0:255];
  end

  assign pc_plus4    = PC.pc_o + 32'd4;
  assign fetch_instr = Instruction_Memory.memory[PC.pc_o[9:2]];

  if (1) begin : IF_ID
    logic [31:0] pc4_reg, instr_reg;
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        pc4_reg   <= '0;
        instr_reg <= '0;
      end else if (!stall) begin
        // Flush on redirect; with the PC frozen, feed nops so the pipe drains
        // instead of re-issuing the same word.
        if (redirect || !start_i) begin
          pc4_reg   <= '0;
          instr_reg <= '0;
        end else begin
          pc4_reg   <= pc_plus4;
          instr_reg <= fetch_instr;
        end
      end
    end
  end

  // ---------------- ID ----------------
  assign id_opcode = IF_ID.instr_reg[31:26];
  assign id_rs     = IF_ID.instr_reg[25:21];
  assign id_rt     = IF_ID.instr_reg[20:16];
  assign id_rd     = IF_ID.instr_reg[15:11];
  assign id_funct  = IF_ID.instr_reg[5:0];
  assign id_imm    = {{16{IF_ID.instr_reg[15]}}, IF_ID.instr_reg[15:0]};

  if (1) begin : Registers
    logic [31:0] register [0:31];
    always_ff @(posedge clk_i) begin
      if (wb_write) register[MEM_WB.dst_reg] <= wb_data;
    end
  end

  // Same-cycle write-back is visible to the ID read.
  assign id_rs_val = (id_rs == '0) ? '0 :
                     (wb_write && MEM_WB.dst_reg == id_rs) ? wb_data : Registers.register[id_rs];
  assign id_rt_val = (id_rt == '0) ? '0 :
                     (wb_write && MEM_WB.dst_reg == id_rt) ? wb_data : Registers.register[id_rt];

  if (1) begin : Control
    always_comb begin
      id_ctrl = CTRL_NOP;
      is_beq  = 1'b0;
      is_j    = 1'b0;
      case (id_opcode)
        OP_RTYPE: begin
          id_ctrl.reg_dst   = 1'b1;
          id_ctrl.reg_write = 1'b1;
          case (id_funct)
            FN_ADD:  id_ctrl.alu_op = ALU_ADD;
            FN_SUB:  id_ctrl.alu_op = ALU_SUB;
            FN_AND:  id_ctrl.alu_op = ALU_AND;
            FN_OR:   id_ctrl.alu_op = ALU_OR;
            FN_MUL:  id_ctrl.alu_op = ALU_MUL;
            default: id_ctrl = CTRL_NOP;
          endcase
        end
        OP_ADDI: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.reg_write = 1'b1;
        end
        OP_LW: begin
          id_ctrl.alu_src    = 1'b1;
          id_ctrl.mem_to_reg = 1'b1;
          id_ctrl.reg_write  = 1'b1;
          id_ctrl.mem_read   = 1'b1;
        end
        OP_SW: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.mem_write = 1'b1;
        end
        OP_BEQ:  is_beq = 1'b1;
        OP_J:    is_j   = 1'b1;
        default: ;
      endcase
    end
  end

  if (1) begin : HazardDetection
    always_comb begin
      stall = ID_EX.ctrl_reg.mem_read && (ID_EX.rt_reg != '0) &&
              (ID_EX.rt_reg == id_rs || ID_EX.rt_reg == id_rt);
    end
  end

  assign redirect  = !stall && (is_j || (is_beq && id_rs_val == id_rt_val));
  assign pc_target = is_j ? {IF_ID.pc4_reg[31:28], IF_ID.instr_reg[25:0], 2'b00}
                          : IF_ID.pc4_reg + (id_imm << 2);

  if (1) begin : ID_EX
    ctrl_t       ctrl_reg;
    logic [31:0] rs_val_reg, rt_val_reg, imm_reg;
    logic [4:0]  rs_reg, rt_reg, rd_reg;
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        ctrl_reg   <= CTRL_NOP;
        rs_val_reg <= '0;
        rt_val_reg <= '0;
        imm_reg    <= '0;
        rs_reg     <= '0;
        rt_reg     <= '0;
        rd_reg     <= '0;
      end else begin
        ctrl_reg   <= stall ? CTRL_NOP : id_ctrl;
        rs_val_reg <= id_rs_val;
        rt_val_reg <= id_rt_val;
        imm_reg    <= id_imm;
        rs_reg     <= id_rs;
        rt_reg     <= id_rt;
        rd_reg     <= id_rd;
      end
    end
  end

  // ---------------- EX ----------------
  if (1) begin : FW
    always_comb begin
      fwd_a = fwd_select(ID_EX.rs_reg, EX_MEM.reg_write_reg, EX_MEM.dst_reg,
                         MEM_WB.reg_write_reg, MEM_WB.dst_reg);
      fwd_b = fwd_select(ID_EX.rt_reg, EX_MEM.reg_write_reg, EX_MEM.dst_reg,
                         MEM_WB.reg_write_reg, MEM_WB.dst_reg);
    end
  end

  always_comb begin
    case (fwd_a)
      FWD_MEM: ex_a = EX_MEM.alu_reg;
      FWD_WB:  ex_a = wb_data;
      default: ex_a = ID_EX.rs_val_reg;
    endcase
    case (fwd_b)
      FWD_MEM: ex_b_fwd = EX_MEM.alu_reg;
      FWD_WB:  ex_b_fwd = wb_data;
      default: ex_b_fwd = ID_EX.rt_val_reg;
    endcase
  end

  assign ex_b   = ID_EX.ctrl_reg.alu_src ? ID_EX.imm_reg : ex_b_fwd;
  assign ex_dst = ID_EX.ctrl_reg.reg_dst ? ID_EX.rd_reg : ID_EX.rt_reg;

  pipelined_cpu_alu alu (
    .a  (ex_a),
    .b  (ex_b),
    .op (ID_EX.ctrl_reg.alu_op),
    .y  (ex_result)
  );

  if (1) begin : EX_MEM
    logic        mem_to_reg_reg, reg_write_reg, mem_write_reg;
    logic [31:0] alu_reg, store_reg;
    logic [4:0]  dst_reg;
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        mem_to_reg_reg <= 1'b0;
        reg_write_reg  <= 1'b0;
        mem_write_reg  <= 1'b0;
        alu_reg        <= '0;
        store_reg      <= '0;
        dst_reg        <= '0;
      end else begin
        mem_to_reg_reg <= ID_EX.ctrl_reg.mem_to_reg;
        reg_write_reg  <= ID_EX.ctrl_reg.reg_write;
        mem_write_reg  <= ID_EX.ctrl_reg.mem_write;
        alu_reg        <= ex_result;
        store_reg      <= ex_b_fwd;
        dst_reg        <= ex_dst;
      end
    end
  end

  // ---------------- MEM ----------------
  assign mem_addr = {EX_MEM.alu_reg[4:2], 2'b00};

  if (1) begin : Data_Memory
    logic [7:0] memory [0:31];
    always_ff @(posedge clk_i) begin
      if (EX_MEM.mem_write_reg) begin
        for (int i = 0; i < 4; i++) memory[mem_addr | 5'(i)] <= EX_MEM.store_reg[8*i +: 8];
      end
    end
  end

  // Little-endian word assembled lane by lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_load_lane
    assign load_data[8*gi +: 8] = Data_Memory.memory[mem_addr | 5'(gi)];
  end

  if (1) begin : MEM_WB
    logic        mem_to_reg_reg, reg_write_reg;
    logic [31:0] alu_reg, load_reg;
    logic [4:0]  dst_reg;
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        mem_to_reg_reg <= 1'b0;
        reg_write_reg  <= 1'b0;
        alu_reg        <= '0;
        load_reg       <= '0;
        dst_reg        <= '0;
      end else begin
        mem_to_reg_reg <= EX_MEM.mem_to_reg_reg;
        reg_write_reg  <= EX_MEM.reg_write_reg;
        alu_reg        <= EX_MEM.alu_reg;
        load_reg       <= load_data;
        dst_reg        <= EX_MEM.dst_reg;
      end
    end
  end

  // ---------------- WB ----------------
  assign wb_data  = MEM_WB.mem_to_reg_reg ? MEM_WB.load_reg : MEM_WB.alu_reg;
  assign wb_write = MEM_WB.reg_write_reg && (MEM_WB.dst_reg != '0);

endmodule

// File: tb/tb_pipelined_cpu.sv
module tb_pipelined_cpu;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
  int pass_count = 0;
  int total_count = 0;
  logic [31:0] prog [0:15];

  always #5 clk_i = ~clk_i;

  pipelined_cpu dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i)
  );

  task automatic step(input int k);
    repeat (k) @(negedge clk_i);
  endtask

  // Hold reset, clear memories/registers, load prog[0..n-1], release with start high.
  task automatic load(input int n);
    rst_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 256; i++) begin
      if (i < n) dut.Instruction_Memory.memory[i] = prog[i];
      else       dut.Instruction_Memory.memory[i] = 32'h0;
    end
    for (int i = 0; i < 32; i++) begin
      dut.Registers.register[i] = 32'h0;
      dut.Data_Memory.memory[i] = 8'h0;
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    start_i = 1'b1;
  endtask

  task automatic test_reset;
    load(0);
    rst_i = 1'b0;
    step(3);
    total_count++;
    if (dut.PC.pc_o !== 32'd0) $display("FAIL reset_pc: got %h expected %h", dut.PC.pc_o, 32'd0);
    else pass_count++;
    total_count++;
    if (dut.IF_ID.instr_reg !== 32'd0) $display("FAIL reset_if_id: got %h expected %h", dut.IF_ID.instr_reg, 32'd0);
    else pass_count++;
    total_count++;
    if (dut.ID_EX.ctrl_reg !== '0) $display("FAIL reset_id_ex_ctrl: got %h expected 0", dut.ID_EX.ctrl_reg);
    else pass_count++;
    start_i = 1'b0;
    rst_i = 1'b1;
    step(3);
    total_count++;
    if (dut.PC.pc_o !== 32'd0) $display("FAIL start_low_hold: got %h expected %h", dut.PC.pc_o, 32'd0);
    else pass_count++;
    start_i = 1'b1;
    step(1);
    total_count++;
    if (dut.PC.pc_o !== 32'd4) $display("FAIL freerun_pc1: got %h expected %h", dut.PC.pc_o, 32'd4);
    else pass_count++;
    step(1);
    total_count++;
    if (dut.PC.pc_o !== 32'd8) $display("FAIL freerun_pc2: got %h expected %h", dut.PC.pc_o, 32'd8);
    else pass_count++;
    step(3);
    total_count++;
    if (dut.PC.pc_o !== 32'd20) $display("FAIL freerun_pc5: got %h expected %h", dut.PC.pc_o, 32'd20);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[8] !== 32'd0) $display("FAIL freerun_reg8: got %h expected %h", dut.Registers.register[8], 32'd0);
    else pass_count++;
    #2 rst_i = 1'b0;
    #1;
    total_count++;
    if (dut.PC.pc_o !== 32'd0) $display("FAIL async_reset_pc: got %h expected %h", dut.PC.pc_o, 32'd0);
    else pass_count++;
    $display("test_reset done");
  endtask

  task automatic test_forwarding;
    prog[0] = 32'h20080005; // addi $8,$0,5
    prog[1] = 32'h21090003; // addi $9,$8,3
    prog[2] = 32'h01285020; // add  $10,$9,$8
    load(3);
    step(3);
    total_count++;
    if (dut.PC.pc_o !== 32'd12) $display("FAIL fwd_no_stall_pc: got %h expected %h", dut.PC.pc_o, 32'd12);
    else pass_count++;
    step(6);
    total_count++;
    if (dut.Registers.register[8] !== 32'd5) $display("FAIL fwd_reg8: got %0d expected %0d", dut.Registers.register[8], 5);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[9] !== 32'd8) $display("FAIL fwd_reg9: got %0d expected %0d", dut.Registers.register[9], 8);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[10] !== 32'd13) $display("FAIL fwd_reg10: got %0d expected %0d", dut.Registers.register[10], 13);
    else pass_count++;
    $display("test_forwarding done");
  endtask

  task automatic test_load_use;
    prog[0] = 32'h8C080000; // lw  $8,0($0)
    prog[1] = 32'h01084820; // add $9,$8,$8
    load(2);
    dut.Data_Memory.memory[0] = 8'd5;
    step(3);
    total_count++;
    if (dut.PC.pc_o !== 32'd8) $display("FAIL loaduse_stall_pc: got %h expected %h", dut.PC.pc_o, 32'd8);
    else pass_count++;
    step(1);
    total_count++;
    if (dut.PC.pc_o !== 32'd12) $display("FAIL loaduse_resume_pc: got %h expected %h", dut.PC.pc_o, 32'd12);
    else pass_count++;
    step(1);
    total_count++;
    if (dut.PC.pc_o !== 32'd16) $display("FAIL loaduse_single_stall_pc: got %h expected %h", dut.PC.pc_o, 32'd16);
    else pass_count++;
    step(6);
    total_count++;
    if (dut.Registers.register[9] !== 32'd10) $display("FAIL loaduse_reg9: got %0d expected %0d", dut.Registers.register[9], 10);
    else pass_count++;
    $display("test_load_use done");
  endtask

  task automatic test_branch;
    prog[0] = 32'h10000001; // beq $0,$0,+1
    prog[1] = 32'h20080001; // addi $8,$0,1
    prog[2] = 32'h20090002; // addi $9,$0,2
    load(3);
    step(2);
    total_count++;
    if (dut.PC.pc_o !== 32'd8) $display("FAIL beq_target_pc: got %h expected %h", dut.PC.pc_o, 32'd8);
    else pass_count++;
    total_count++;
    if (dut.IF_ID.instr_reg !== 32'd0) $display("FAIL beq_flush: got %h expected %h", dut.IF_ID.instr_reg, 32'd0);
    else pass_count++;
    step(6);
    total_count++;
    if (dut.Registers.register[8] !== 32'd0) $display("FAIL beq_skipped_reg8: got %0d expected %0d", dut.Registers.register[8], 0);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[9] !== 32'd2) $display("FAIL beq_reg9: got %0d expected %0d", dut.Registers.register[9], 2);
    else pass_count++;
    $display("test_branch done");
  endtask

  task automatic test_jump;
    prog[0] = 32'h08000003; // j 3
    prog[1] = 32'h20080001; // addi $8,$0,1
    prog[2] = 32'h20090002; // addi $9,$0,2
    prog[3] = 32'h200A0007; // addi $10,$0,7
    load(4);
    step(2);
    total_count++;
    if (dut.PC.pc_o !== 32'd12) $display("FAIL j_target_pc: got %h expected %h", dut.PC.pc_o, 32'd12);
    else pass_count++;
    total_count++;
    if (dut.IF_ID.instr_reg !== 32'd0) $display("FAIL j_flush: got %h expected %h", dut.IF_ID.instr_reg, 32'd0);
    else pass_count++;
    step(1);
    total_count++;
    if (dut.IF_ID.instr_reg !== 32'h200A0007) $display("FAIL j_fetch_target: got %h expected %h", dut.IF_ID.instr_reg, 32'h200A0007);
    else pass_count++;
    step(6);
    total_count++;
    if (dut.Registers.register[8] !== 32'd0 || dut.Registers.register[9] !== 32'd0)
      $display("FAIL j_skipped: got %h/%h expected 0/0", dut.Registers.register[8], dut.Registers.register[9]);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[10] !== 32'd7) $display("FAIL j_reg10: got %0d expected %0d", dut.Registers.register[10], 7);
    else pass_count++;
    $display("test_jump done");
  endtask

  task automatic test_store_load;
    logic [31:0] word;
    prog[0] = 32'h2008FFFE; // addi $8,$0,-2
    prog[1] = 32'hAC080004; // sw   $8,4($0)
    prog[2] = 32'h8C090004; // lw   $9,4($0)
    load(3);
    step(10);
    word = {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
            dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]};
    total_count++;
    if (word !== 32'hFFFFFFFE) $display("FAIL sw_bytes: got %h expected %h", word, 32'hFFFFFFFE);
    else pass_count++;
    total_count++;
    if (dut.Data_Memory.memory[4] !== 8'hFE) $display("FAIL sw_byte4: got %h expected %h", dut.Data_Memory.memory[4], 8'hFE);
    else pass_count++;
    total_count++;
    if (dut.Data_Memory.memory[3] !== 8'h00 || dut.Data_Memory.memory[8] !== 8'h00)
      $display("FAIL sw_neighbors: got %h/%h expected 00/00", dut.Data_Memory.memory[3], dut.Data_Memory.memory[8]);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[9] !== 32'hFFFFFFFE) $display("FAIL lw_reg9: got %h expected %h", dut.Registers.register[9], 32'hFFFFFFFE);
    else pass_count++;
    $display("test_store_load done");
  endtask

  task automatic test_back_to_back;
    prog[0] = 32'h20080006; // addi $8,$0,6
    prog[1] = 32'h20090007; // addi $9,$0,7
    prog[2] = 32'h01095018; // mul  $10,$8,$9  -> 42
    prog[3] = 32'h01485822; // sub  $11,$10,$8 -> 36
    prog[4] = 32'h01496024; // and  $12,$10,$9 -> 2
    prog[5] = 32'h01096825; // or   $13,$8,$9  -> 7
    prog[6] = 32'h20000005; // addi $0,$0,5 (discarded)
    prog[7] = 32'h200E0001; // addi $14,$0,1 -> 1, $0 must not forward
    load(8);
    step(8);
    total_count++;
    if (dut.PC.pc_o !== 32'd32) $display("FAIL b2b_no_stall_pc: got %h expected %h", dut.PC.pc_o, 32'd32);
    else pass_count++;
    step(8);
    total_count++;
    if (dut.Registers.register[10] !== 32'd42) $display("FAIL b2b_mul: got %0d expected %0d", dut.Registers.register[10], 42);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[11] !== 32'd36) $display("FAIL b2b_sub: got %0d expected %0d", dut.Registers.register[11], 36);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[12] !== 32'd2) $display("FAIL b2b_and: got %0d expected %0d", dut.Registers.register[12], 2);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[13] !== 32'd7) $display("FAIL b2b_or: got %0d expected %0d", dut.Registers.register[13], 7);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[0] !== 32'd0) $display("FAIL b2b_reg0: got %0d expected %0d", dut.Registers.register[0], 0);
    else pass_count++;
    total_count++;
    if (dut.Registers.register[14] !== 32'd1) $display("FAIL b2b_zero_src: got %0d expected %0d", dut.Registers.register[14], 1);
    else pass_count++;
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_jump();
    test_store_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
